// File: rtl/cipher_burst_reader.sv
// cipher_burst_reader: burst read-back engine for the 64-bit encrypted store.
// Issues sequential reads, undoes the store's 4-round rotate/xor cipher in a
// 4-stage non-stalling pipeline and streams plaintext through a small FIFO.
// The read credit (in-flight reads plus buffered words) is what keeps the FIFO
// from overflowing, because the pipeline itself cannot be stalled.
module cipher_burst_reader #(
  parameter int FIFO_DEPTH = 8,
  parameter int ROT        = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] base_addr,
  input  logic [14:0] length,
  input  logic [63:0] key,
  output logic        busy,
  output logic        done,
  output logic        R_EN,
  output logic [13:0] R_ADDR,
  input  logic [63:0] rd_data,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
    logic [5:0] s;
    s = n[5:0];
    return (x << s) | (x >> (7'd64 - {1'b0, s}));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    logic [5:0] s;
    s = n[5:0];
    return (x >> s) | (x << (7'd64 - {1'b0, s}));
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  state_t        r_state;
  state_t        w_state_next;
  logic [63:0]   r_key;
  logic [13:0]   r_addr;
  logic [14:0]   r_remain;
  logic [14:0]   r_len;
  logic [14:0]   r_delivered;
  logic [CW-1:0] r_in_flight;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [63:0]   r_fifo [FIFO_DEPTH];
  logic          r_mem_valid;
  logic          r_stg_valid [4];
  logic [63:0]   r_stg_data  [4];

  logic [63:0]   w_rk [4];
  logic [CW:0]   w_credit;
  logic          w_ren;
  logic          w_busy;
  logic          w_done;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_last_word;

  assign w_credit    = {1'b0, r_in_flight} + {1'b0, r_count};
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && m_ready;
  assign w_push      = r_stg_valid[3];
  assign w_last_word = ((r_delivered + 15'd1) == r_len);

  // Round keys are rotations of the key captured at start.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rk
      assign w_rk[gi] = rotl64(r_key, 16 * gi);
    end
  endgenerate

  // Inverse cipher: stage gi undoes encryption round 3-gi; never stalls.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stage
      logic        w_vin;
      logic [63:0] w_din;
      if (gi == 0) begin : g_first
        assign w_vin = r_mem_valid;
        assign w_din = rd_data;
      end else begin : g_rest
        assign w_vin = r_stg_valid[gi-1];
        assign w_din = r_stg_data[gi-1];
      end
      // One decryption round per pipeline stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_stg_valid[gi] <= 1'b0;
          r_stg_data[gi]  <= '0;
        end else begin
          r_stg_valid[gi] <= w_vin;
          r_stg_data[gi]  <= rotr64(w_din, ROT) ^ w_rk[3-gi];
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and control outputs; reads are issued only while credit remains.
  always_comb begin
    w_state_next = r_state;
    w_ren        = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_ren  = (w_credit < DEPTH_C);
        if (w_ren && (r_remain == 15'd1)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_pop && w_last_word) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Burst parameters, address/remaining counters and delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key       <= '0;
      r_addr      <= '0;
      r_remain    <= '0;
      r_len       <= '0;
      r_delivered <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_key       <= key;
      r_addr      <= base_addr;
      r_remain    <= length;
      r_len       <= length;
      r_delivered <= '0;
    end else begin
      if (w_ren) begin
        r_addr   <= r_addr + 14'd1;
        r_remain <= r_remain - 15'd1;
      end
      if (w_pop) begin
        r_delivered <= r_delivered + 15'd1;
      end
    end
  end

  // Reads in flight: memory cycle plus the four pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_valid <= 1'b0;
      r_in_flight <= '0;
    end else begin
      r_mem_valid <= w_ren;
      case ({w_ren, w_push})
        2'b10:   r_in_flight <= r_in_flight + 1'b1;
        2'b01:   r_in_flight <= r_in_flight - 1'b1;
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

  // Output FIFO; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_stg_data[3];
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy    = w_busy;
  assign done    = w_done;
  assign R_EN    = w_ren;
  assign R_ADDR  = r_addr;
  assign m_valid = w_valid;
  assign m_data  = w_valid ? r_fifo[r_rd_ptr] : '0;
  assign m_last  = w_valid && w_last_word;

endmodule

// File: tb/tb_cipher_burst_reader.sv
// Directed bench for cipher_burst_reader: a behavioural encrypted store
// answers reads one cycle later, a monitor logs reads/handshakes/done pulses,
// and the main sequence checks each burst against hand-chosen plaintext.
module tb_cipher_burst_reader;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] length;
  logic [63:0] key;
  logic        busy;
  logic        done;
  logic        R_EN;
  logic [13:0] R_ADDR;
  logic [63:0] rd_data = '0;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cipher_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .key(key), .busy(busy), .done(done), .R_EN(R_EN), .R_ADDR(R_ADDR),
    .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
  );

  // Encrypted store: data valid the cycle after R_EN
  logic [63:0] store [0:16383];
  always @(posedge clk) if (R_EN) rd_data <= store[R_ADDR];

  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  // Write-side encryption, used only to fill the store
  function automatic logic [63:0] enc(input logic [63:0] p, input logic [63:0] k);
    logic [63:0] x;
    x = p;
    for (int r = 0; r < 4; r++) x = rotl(x ^ rotl(k, 16 * r), 7);
    return x;
  endfunction

  // Monitor
  int          cyc = 0;
  logic [13:0] addr_q[$];
  int          ren_cyc_q[$];
  logic [63:0] data_q[$];
  logic        last_q[$];
  int          hs_cyc_q[$];
  int          done_cnt = 0;
  int          valid_cyc_cnt = 0;
  int          outstanding = 0;
  int          max_out = 0;
  int          hold_err = 0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_hold   = 1'b0;
      outstanding = 0;
    end else begin
      if (prev_hold && (!m_valid || m_data !== prev_data || m_last !== prev_last)) hold_err++;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (R_EN) begin
        addr_q.push_back(R_ADDR);
        ren_cyc_q.push_back(cyc);
        outstanding++;
      end
      if (m_valid) valid_cyc_cnt++;
      if (m_valid && m_ready) begin
        data_q.push_back(m_data);
        last_q.push_back(m_last);
        hs_cyc_q.push_back(cyc);
        outstanding--;
      end
      if (done) done_cnt++;
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-burst bookkeeping
  int          t0, a0, d0, dn0, v0, done_rel;
  logic        c1_busy, c1_ren;
  logic [13:0] c1_addr;

  // mode 0: m_ready held 1; mode 1: m_ready high one cycle in three
  task automatic run_burst(input logic [13:0] b, input logic [14:0] n, input logic [63:0] k,
                           input int mode, input bit poke);
    int waited;
    @(negedge clk);
    a0 = addr_q.size(); d0 = data_q.size(); dn0 = done_cnt; v0 = valid_cyc_cnt;
    base_addr = b; length = n; key = k; start = 1'b1; m_ready = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    c1_busy = busy; c1_ren = R_EN; c1_addr = R_ADDR;
    waited = 1;
    done_rel = -1;
    while (waited < 400 && done_rel < 0) begin
      if (done) begin
        done_rel = cyc - t0;
      end else begin
        if (mode == 1) m_ready = (((cyc - t0) % 3) == 0);
        if (poke && waited == 3) begin
          start = 1'b1; length = 15'd5; base_addr = b + 14'd5;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        waited++;
      end
    end
    checks++;
    assert (done_rel >= 0) else begin
      errors++;
      $error("FAIL done_timeout: observed no done expected done within 400 cycles");
    end
    m_ready = 1'b1;
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; key = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ren", R_EN, 0);
    chk("rst_addr", R_ADDR, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b0;

    // Test 1: key 0, base 1, length 3
    store[1] = 64'h0000_0000_A000_0000;
    store[2] = 64'h0000_0001_4000_0000;
    store[3] = 64'h0000_0001_E000_0000;
    run_burst(14'd1, 15'd3, 64'h0, 0, 1'b0);
    chk("t1_c1_busy", c1_busy, 1);
    chk("t1_c1_ren", c1_ren, 1);
    chk("t1_c1_addr", c1_addr, 1);
    chk("t1_nwords", data_q.size() - d0, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_data%0d", i), data_q[d0+i], 64'(10 * (i + 1)));
      chk($sformatf("t1_cyc%0d", i), hs_cyc_q[d0+i] - t0, 7 + i);
      chk($sformatf("t1_last%0d", i), last_q[d0+i], (i == 2) ? 1 : 0);
    end
    chk("t1_done_cyc", done_rel, 10);
    chk("t1_done_cnt", done_cnt - dn0, 1);
    chk("t1_after_done", done, 0);
    chk("t1_after_busy", busy, 0);

    // Test 2: all-ones key, same store gives the same plaintext
    run_burst(14'd1, 15'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t2_data%0d", i), data_q[d0+i], 64'(10 * (i + 1)));

    // Test 3: wrong key must not recover the plaintext
    run_burst(14'd1, 15'd3, 64'h1, 0, 1'b0);
    checks++;
    assert (data_q[d0] !== 64'd10) else begin
      errors++;
      $error("FAIL t3_wrong_key: observed %0h expected value other than a", data_q[d0]);
    end

    // Test 4: address wrap 16382 -> 1
    store[16382] = enc(64'd500, 64'h0123_4567_89AB_CDEF);
    store[16383] = enc(64'd501, 64'h0123_4567_89AB_CDEF);
    store[0]     = enc(64'd502, 64'h0123_4567_89AB_CDEF);
    store[1]     = enc(64'd503, 64'h0123_4567_89AB_CDEF);
    run_burst(14'd16382, 15'd4, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
    chk("t4_nreads", addr_q.size() - a0, 4);
    chk("t4_addr0", addr_q[a0+0], 16382);
    chk("t4_addr1", addr_q[a0+1], 16383);
    chk("t4_addr2", addr_q[a0+2], 0);
    chk("t4_addr3", addr_q[a0+3], 1);
    chk("t4_nwords", data_q.size() - d0, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_data%0d", i), data_q[d0+i], 64'(500 + i));
      chk($sformatf("t4_last%0d", i), last_q[d0+i], (i == 3) ? 1 : 0);
    end
    chk("t4_done_cyc", done_rel, 11);

    // Test 5: back-pressure, m_ready one cycle in three
    for (int i = 0; i < 16; i++) store[100+i] = enc(64'h1000 + 64'(i), 64'hDEAD_BEEF_0BAD_F00D);
    run_burst(14'd100, 15'd16, 64'hDEAD_BEEF_0BAD_F00D, 1, 1'b0);
    chk("t5_nwords", data_q.size() - d0, 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t5_data%0d", i), data_q[d0+i], 64'h1000 + 64'(i));
    chk("t5_last15", last_q[d0+15], 1);
    chk("t5_last14", last_q[d0+14], 0);
    chk("t5_done_cnt", done_cnt - dn0, 1);
    chk("t5_ren_gaps", (ren_cyc_q[a0+15] - ren_cyc_q[a0]) > 15, 1);
    chk("t5_max_buffered", max_out <= DEPTH, 1);
    chk("t5_hold_stable", hold_err, 0);

    // Test 6: length 0
    run_burst(14'd50, 15'd0, 64'h5, 0, 1'b0);
    chk("t6_nreads", addr_q.size() - a0, 0);
    chk("t6_valid_cycles", valid_cyc_cnt - v0, 0);
    chk("t6_done_cyc", done_rel, 1);
    chk("t6_done_cnt", done_cnt - dn0, 1);

    // Test 7: start while busy is ignored
    for (int i = 0; i < 11; i++) store[300+i] = enc(64'h7700 + 64'(i), 64'h0F0F_0F0F_1234_5678);
    run_burst(14'd300, 15'd6, 64'h0F0F_0F0F_1234_5678, 0, 1'b1);
    chk("t7_nreads", addr_q.size() - a0, 6);
    chk("t7_nwords", data_q.size() - d0, 6);
    chk("t7_data5", data_q[d0+5], 64'h7705);
    chk("t7_done_cnt", done_cnt - dn0, 1);
    chk("t7_done_cyc", done_rel, 13);

    // Test 8: reset at cycle 4 of a length-10 burst, then a fresh burst
    for (int i = 0; i < 10; i++) store[400+i] = enc(64'hA0 + 64'(i), 64'h1111_2222_3333_4444);
    @(negedge clk);
    base_addr = 14'd400; length = 15'd10; key = 64'h1111_2222_3333_4444; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t8_busy", busy, 0);
    chk("t8_done", done, 0);
    chk("t8_ren", R_EN, 0);
    chk("t8_addr", R_ADDR, 0);
    chk("t8_valid", m_valid, 0);
    chk("t8_last", m_last, 0);
    chk("t8_data", m_data, 0);
    rst = 1'b0;
    dn0 = done_cnt; v0 = valid_cyc_cnt;
    repeat (15) @(negedge clk);
    chk("t8_no_done", done_cnt - dn0, 0);
    chk("t8_no_valid", valid_cyc_cnt - v0, 0);
    run_burst(14'd400, 15'd3, 64'h1111_2222_3333_4444, 0, 1'b0);
    chk("t8_fresh_addr0", addr_q[a0], 400);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t8_fresh_data%0d", i), data_q[d0+i], 64'hA0 + 64'(i));
    chk("t8_fresh_first_cyc", hs_cyc_q[d0] - t0, 7);
    chk("t8_fresh_done_cyc", done_rel, 10);

    chk("final_max_buffered", max_out <= DEPTH, 1);
    chk("final_hold_stable", hold_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
